// File: rtl/store_merger_pkg.sv
// rtl/store_merger_pkg.sv - shared state encoding, size codes and alignment helpers for store_merger
package store_merger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // Byte wins over Half; neither selected means a full word.
    function automatic size_t size_decode(input logic byte_sel, input logic half_sel);
        size_t sz;
        if (byte_sel) begin
            sz = SZ_BYTE;
        end else if (half_sel) begin
            sz = SZ_HALF;
        end else begin
            sz = SZ_WORD;
        end
        return sz;
    endfunction

    function automatic logic misaligned(input size_t sz, input logic [1:0] lsb);
        logic bad;
        case (sz)
            SZ_HALF: bad = lsb[0];
            SZ_WORD: bad = (lsb != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// rtl/store_lane_merge.sv - places the low byte/halfword of d into its little-endian lane of old_word
//
// Ports:
//   old_word  in  32  word read back from memory
//   d         in  32  register value being stored
//   lsb       in  2   byte address bits [1:0]
//   byte_sel  in  1   byte store (has priority over half_sel)
//   half_sel  in  1   halfword store
//   merged    out 32  word to write back
module store_lane_merge
    import store_merger_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] d,
    input  logic [1:0]  lsb,
    input  logic        byte_sel,
    input  logic        half_sel,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        case (size_decode(byte_sel, half_sel))
            SZ_BYTE: begin
                case (lsb)
                    2'd0:    merged[7:0]   = d[7:0];
                    2'd1:    merged[15:8]  = d[7:0];
                    2'd2:    merged[23:16] = d[7:0];
                    default: merged[31:24] = d[7:0];
                endcase
            end
            SZ_HALF: begin
                if (lsb[1]) begin
                    merged[31:16] = d[15:0];
                end else begin
                    merged[15:0]  = d[15:0];
                end
            end
            default: merged = d;
        endcase
    end

endmodule

// File: rtl/store_merger.sv
// rtl/store_merger.sv - byte/half/word store unit using read-modify-write on a word-only memory
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   Req, Ready            store request / idle handshake
//   Addr, D, Byte, Half   store byte address, data and size (sampled at accept only)
//   Done, Err             one-cycle completion / misalignment pulses
//   Mem_Addr              word address of the store
//   Mem_Re, Mem_Rdata     read strobe and read data (MEM_LAT cycles later)
//   Mem_We, Mem_Wdata     write strobe and merged write word
module store_merger
    import store_merger_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Req,
    output logic              Ready,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       D,
    input  logic              Byte,
    input  logic              Half,
    output logic              Done,
    output logic              Err,
    output logic [ADDR_W-3:0] Mem_Addr,
    output logic              Mem_Re,
    input  logic [31:0]       Mem_Rdata,
    output logic              Mem_We,
    output logic [31:0]       Mem_Wdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       d_q;
    logic              byte_q;
    logic              half_q;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [31:0]       merged;
    logic              accept;
    logic              wait_last;
    size_t             req_size;

    assign req_size  = size_decode(Byte, Half);
    assign accept    = (state == ST_IDLE) && Req;
    assign wait_last = (state == ST_WAIT) && (wait_cnt == '0);

    store_lane_merge u_merge (
        .old_word (Mem_Rdata),
        .d        (d_q),
        .lsb      (addr_q[1:0]),
        .byte_sel (byte_q),
        .half_sel (half_q),
        .merged   (merged)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (Req) begin
                    if (misaligned(req_size, Addr[1:0])) begin
                        state_nxt = ST_ERR;
                    end else if (req_size == SZ_WORD) begin
                        state_nxt = ST_WRITE;
                    end else begin
                        state_nxt = ST_READ;
                    end
                end
            end
            ST_READ:  state_nxt = ST_WAIT;
            ST_WAIT:  if (wait_cnt == '0) state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            ST_ERR:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        Ready  = (state == ST_IDLE);
        Mem_Re = (state == ST_READ);
        Mem_We = (state == ST_WRITE);
        Done   = (state == ST_DONE);
        Err    = (state == ST_ERR);
    end

    // Word stores take D straight into the write register at accept; sub-word
    // stores load it from the merge on the edge that ends the last WAIT cycle,
    // which is exactly when the memory's read data is valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q   <= '0;
            d_q      <= '0;
            byte_q   <= 1'b0;
            half_q   <= 1'b0;
            wdata_q  <= '0;
            wait_cnt <= '0;
        end else begin
            if (accept) begin
                addr_q <= Addr;
                d_q    <= D;
                byte_q <= Byte;
                half_q <= Half;
                if (req_size == SZ_WORD) begin
                    wdata_q <= D;
                end
            end
            if (wait_last) begin
                wdata_q <= merged;
            end
            if (state == ST_READ) begin
                wait_cnt <= CNT_W'(MEM_LAT - 1);
            end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    assign Mem_Addr  = addr_q[ADDR_W-1:2];
    assign Mem_Wdata = wdata_q;

endmodule

// File: tb/tb_store_merger.sv
// tb/tb_store_merger.sv - table-driven self-checking bench for store_merger
module tb_store_merger;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Req;
    logic        Ready;
    logic [15:0] Addr;
    logic [31:0] D;
    logic        Byte;
    logic        Half;
    logic        Done;
    logic        Err;
    logic [13:0] Mem_Addr;
    logic        Mem_Re;
    logic [31:0] Mem_Rdata;
    logic        Mem_We;
    logic [31:0] Mem_Wdata;

    logic [31:0] rd_word;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    store_merger #(.ADDR_W(16), .MEM_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Req       (Req),
        .Ready     (Ready),
        .Addr      (Addr),
        .D         (D),
        .Byte      (Byte),
        .Half      (Half),
        .Done      (Done),
        .Err       (Err),
        .Mem_Addr  (Mem_Addr),
        .Mem_Re    (Mem_Re),
        .Mem_Rdata (Mem_Rdata),
        .Mem_We    (Mem_We),
        .Mem_Wdata (Mem_Wdata)
    );

    // One-cycle-latency memory; outside the valid cycle it returns a poison word
    always @(posedge clk) begin
        Mem_Rdata <= Mem_Re ? rd_word : 32'h0BAD_0BAD;
    end

    typedef struct {
        logic [15:0] addr;
        logic [31:0] d;
        logic        b;
        logic        h;
        logic [31:0] init;
        int          e_re;
        int          e_we;
        int          e_done;
        int          e_err;
        int          e_rdy;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs[12];

    int          re_cyc, we_cyc, done_cyc, err_cyc, rdy_cyc, re_cnt, we_cnt;
    logic [31:0] we_data;
    logic [13:0] we_addr;
    bit          addr_bad, inv_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic run_store(input logic [15:0] a, input logic [31:0] dd,
                             input logic b, input logic h, input bit hold);
        @(negedge clk);
        Addr = a; D = dd; Byte = b; Half = h; Req = 1'b1;
        re_cyc = 0; we_cyc = 0; done_cyc = 0; err_cyc = 0; rdy_cyc = 0;
        re_cnt = 0; we_cnt = 0; we_data = '0; we_addr = '0;
        addr_bad = 1'b0; inv_bad = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (Mem_Re) begin re_cnt++; if (re_cyc == 0) re_cyc = k; end
            if (Mem_We) begin
                we_cnt++;
                if (we_cyc == 0) we_cyc = k;
                we_data = Mem_Wdata;
                we_addr = Mem_Addr;
            end
            if (Done && done_cyc == 0) done_cyc = k;
            if (Err && err_cyc == 0) err_cyc = k;
            if (Ready && rdy_cyc == 0) rdy_cyc = k;
            if (Done && Err) inv_bad = 1'b1;
            if (Ready && (Done || Err || Mem_Re || Mem_We)) inv_bad = 1'b1;
            if (rdy_cyc == 0 && Mem_Addr !== a[15:2]) addr_bad = 1'b1;
            if (k == 1) begin
                Addr = ~a; D = ~dd; Byte = ~b; Half = ~h;
                if (!hold) Req = 1'b0;
            end
            if (hold && Ready) Req = 1'b0;
        end
        Req = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{16'h0010, 32'hDEADBEEF, 0, 0, 32'h11223344, 0, 1, 2, 0, 3, 32'hDEADBEEF};
        vecs[1]  = '{16'h0006, 32'hFFFFFFAB, 1, 0, 32'h11223344, 1, 3, 4, 0, 5, 32'h11AB3344};
        vecs[2]  = '{16'h000A, 32'h0000CAFE, 0, 1, 32'h11223344, 1, 3, 4, 0, 5, 32'hCAFE3344};
        vecs[3]  = '{16'h0003, 32'h0000005A, 1, 1, 32'h11223344, 1, 3, 4, 0, 5, 32'h5A223344};
        vecs[4]  = '{16'h0001, 32'h00001234, 0, 1, 32'h11223344, 0, 0, 0, 1, 2, 32'h0};
        vecs[5]  = '{16'h0002, 32'h00001234, 0, 0, 32'h11223344, 0, 0, 0, 1, 2, 32'h0};
        vecs[6]  = '{16'h0004, 32'h12345678, 1, 0, 32'hAABBCCDD, 1, 3, 4, 0, 5, 32'hAABBCC78};
        vecs[7]  = '{16'h0005, 32'h00000099, 1, 0, 32'hAABBCCDD, 1, 3, 4, 0, 5, 32'hAABB99DD};
        vecs[8]  = '{16'h0008, 32'hFFFF1234, 0, 1, 32'hAABBCCDD, 1, 3, 4, 0, 5, 32'hAABB1234};
        vecs[9]  = '{16'hFFFC, 32'h01020304, 0, 0, 32'hAABBCCDD, 0, 1, 2, 0, 3, 32'h01020304};
        vecs[10] = '{16'h0003, 32'h0000BEEF, 0, 1, 32'hAABBCCDD, 0, 0, 0, 1, 2, 32'h0};
        vecs[11] = '{16'h0011, 32'h0000BEEF, 0, 0, 32'hAABBCCDD, 0, 0, 0, 1, 2, 32'h0};

        rst_n = 1'b0; Req = 1'b0; Addr = '0; D = '0; Byte = 1'b0; Half = 1'b0;
        rd_word = '0;

        // Reset held for two edges
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {31'd0, Ready}, 32'd1);
        chk("reset_strobes", {28'd0, Done, Err, Mem_Re, Mem_We}, 32'd0);
        chk("reset_wdata", Mem_Wdata, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            rd_word = vecs[i].init;
            run_store(vecs[i].addr, vecs[i].d, vecs[i].b, vecs[i].h, 1'b0);
            chk($sformatf("v%0d_re_cyc", i), re_cyc, vecs[i].e_re);
            chk($sformatf("v%0d_we_cyc", i), we_cyc, vecs[i].e_we);
            chk($sformatf("v%0d_done_cyc", i), done_cyc, vecs[i].e_done);
            chk($sformatf("v%0d_err_cyc", i), err_cyc, vecs[i].e_err);
            chk($sformatf("v%0d_ready_cyc", i), rdy_cyc, vecs[i].e_rdy);
            chk($sformatf("v%0d_re_count", i), re_cnt, (vecs[i].e_re != 0) ? 1 : 0);
            chk($sformatf("v%0d_we_count", i), we_cnt, (vecs[i].e_we != 0) ? 1 : 0);
            chk($sformatf("v%0d_addr_stable", i), {31'd0, addr_bad}, 32'd0);
            chk($sformatf("v%0d_invariants", i), {31'd0, inv_bad}, 32'd0);
            if (vecs[i].e_we != 0) begin
                chk($sformatf("v%0d_wdata", i), we_data, vecs[i].e_wdata);
                chk($sformatf("v%0d_mem_addr", i), {18'd0, we_addr}, {18'd0, vecs[i].addr[15:2]});
            end
        end

        // Req held high through a whole byte store: exactly one store
        rd_word = 32'h11223344;
        run_store(16'h0006, 32'h000000AB, 1'b1, 1'b0, 1'b1);
        chk("hold_we_count", we_cnt, 1);
        chk("hold_re_count", re_cnt, 1);
        chk("hold_wdata", we_data, 32'h11AB3344);
        chk("hold_ready_cyc", rdy_cyc, 5);
        @(negedge clk);
        chk("hold_no_reaccept", {31'd0, Ready}, 32'd1);

        // Req held high on a misaligned word: one Err, then idle
        run_store(16'h0002, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("hold_err_cyc", err_cyc, 1);
        chk("hold_err_we", we_cnt, 0);
        chk("hold_err_ready", rdy_cyc, 2);

        // Reset during WAIT aborts the store
        rd_word = 32'h11223344;
        @(negedge clk);
        Addr = 16'h0006; D = 32'hAB; Byte = 1'b1; Half = 1'b0; Req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Req = 1'b0;
        chk("rstwait_read", {31'd0, Mem_Re}, 32'd1);
        @(negedge clk);
        chk("rstwait_in_wait", {30'd0, Mem_Re, Mem_We}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstwait_ready", {31'd0, Ready}, 32'd1);
        chk("rstwait_wdata", Mem_Wdata, 32'd0);
        we_cnt = 0; done_cyc = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (Mem_We) we_cnt++;
            if (Done) done_cyc++;
        end
        chk("rstwait_no_we", we_cnt, 0);
        chk("rstwait_no_done", done_cyc, 0);
        chk("rstwait_ready_after", {31'd0, Ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
